// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - sequential fully-connected layer, one signed fixed-point MAC per cycle
module fc_layer_seq #(
   parameter int DATA_W  = 32,
   parameter int FRAC_W  = 16,
   parameter int IN_DIM  = 1,
   parameter int OUT_DIM = 1,
   parameter int ACC_W   = 2*DATA_W+8,
   parameter int RELU    = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_W*OUT_DIM*IN_DIM-1:0]  w_flat,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_W*IN_DIM-1:0]          x_flat,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_W*OUT_DIM-1:0]         y_flat,
   output logic                              busy
);

   localparam int IW = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
   localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(IN_DIM-1);
   localparam logic [OW-1:0] O_LAST = OW'(OUT_DIM-1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                     state, state_nx;
   logic [DATA_W*IN_DIM-1:0]   x_reg;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    sum;
   logic signed [ACC_W-1:0]    shifted;
   logic [IW-1:0]              i_cnt;
   logic [OW-1:0]              o_cnt;
   logic signed [DATA_W-1:0]   w_sel;
   logic signed [DATA_W-1:0]   x_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]          post_val;
   logic                       last_i;
   logic                       last_o;

   assign last_i  = (i_cnt == I_LAST);
   assign last_o  = (o_cnt == O_LAST);
   assign w_sel   = w_flat[(int'(o_cnt)*IN_DIM + int'(i_cnt))*DATA_W +: DATA_W];
   assign x_sel   = x_reg[int'(i_cnt)*DATA_W +: DATA_W];
   assign prod    = w_sel * x_sel;
   assign sum     = acc + ACC_W'(prod);
   assign shifted = sum >>> FRAC_W;

   // Floor shift, then clamp to the element range, then optional ReLU.
   always_comb begin
      post_val = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX)
         post_val = {1'b0, {(DATA_W-1){1'b1}}};
      else if (shifted < SAT_MIN)
         post_val = {1'b1, {(DATA_W-1){1'b0}}};
      if (RELU != 0 && post_val[DATA_W-1])
         post_val = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)         state_nx = MAC;
         MAC:     if (last_i && last_o) state_nx = OUT;
         OUT:     if (out_ready)        state_nx = IDLE;
         default:                       state_nx = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == MAC);
   assign out_valid = (state == OUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg  <= '0;
         acc    <= '0;
         i_cnt  <= '0;
         o_cnt  <= '0;
         y_flat <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg <= x_flat;
                  acc   <= '0;
                  i_cnt <= '0;
                  o_cnt <= '0;
               end
            end
            MAC: begin
               if (last_i) begin
                  y_flat[int'(o_cnt)*DATA_W +: DATA_W] <= post_val;
                  acc   <= '0;
                  i_cnt <= '0;
                  o_cnt <= last_o ? '0 : o_cnt + OW'(1);
               end else begin
                  acc   <= sum;
                  i_cnt <= i_cnt + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - scoreboard bench for fc_layer_seq (2x2 linear, 2x2 ReLU, 1x1 linear)
module tb_fc_layer_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv   [3];
   logic        ordy [3];
   logic [63:0] w_bus [3];
   logic [31:0] x_bus [3];
   logic        irdy [3];
   logic        ov   [3];
   logic        bsy  [3];
   logic [31:0] y_bus [3];
   logic [31:0] y_a, y_r;
   logic [15:0] y_s;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [31:0] exp_y   [3][$];
   int          exp_lat [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign y_bus[0] = y_a;
   assign y_bus[1] = y_r;
   assign y_bus[2] = {16'h0000, y_s};

   fc_layer_seq #(.DATA_W(16), .FRAC_W(8), .IN_DIM(2), .OUT_DIM(2), .RELU(0)) dut_a (
      .clk(clk), .rst(rst), .w_flat(w_bus[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
      .x_flat(x_bus[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y_flat(y_a), .busy(bsy[0]));

   fc_layer_seq #(.DATA_W(16), .FRAC_W(8), .IN_DIM(2), .OUT_DIM(2), .RELU(1)) dut_r (
      .clk(clk), .rst(rst), .w_flat(w_bus[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
      .x_flat(x_bus[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .y_flat(y_r), .busy(bsy[1]));

   fc_layer_seq #(.DATA_W(16), .FRAC_W(8), .IN_DIM(1), .OUT_DIM(1), .RELU(0)) dut_s (
      .clk(clk), .rst(rst), .w_flat(w_bus[2][15:0]), .in_valid(iv[2]), .in_ready(irdy[2]),
      .x_flat(x_bus[2][15:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .y_flat(y_s), .busy(bsy[2]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Monitor: latency on out_valid rise, result value on output handshake.
   for (genvar k = 0; k < 3; k++) begin : g_mon
      logic ov_prev  = 1'b0;
      int   acc_edge = 0;
      always @(negedge clk) begin
         if (!rst) begin
            if (iv[k] && irdy[k])
               acc_edge = cyc + 1;
            if (ov[k] && !ov_prev) begin
               if (exp_lat[k].size() == 0)
                  chk($sformatf("unexpected_valid_%0d", k), 64'(ov[k]), 64'd0);
               else
                  chk($sformatf("latency_%0d", k), 64'(cyc - acc_edge), 64'(exp_lat[k].pop_front()));
            end
            if (ov[k] && ordy[k]) begin
               if (exp_y[k].size() == 0)
                  chk($sformatf("unexpected_out_%0d", k), 64'(y_bus[k]), 64'd0);
               else
                  chk($sformatf("y_%0d", k), 64'(y_bus[k]), 64'(exp_y[k].pop_front()));
            end
         end
         ov_prev = rst ? 1'b0 : ov[k];
      end
   end

   task automatic expect_out(input int k, input logic [31:0] y, input int lat);
      exp_y[k].push_back(y);
      exp_lat[k].push_back(lat);
   endtask

   task automatic send(input int k, input logic [31:0] x, input logic [63:0] w);
      bit got = 1'b0;
      @(posedge clk); #1;
      x_bus[k] = x;
      w_bus[k] = w;
      iv[k]    = 1'b1;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         if (irdy[k]) got = 1'b1;
      end
      @(posedge clk); #1;
      iv[k] = 1'b0;
      if (!got) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle(input int k);
      bit done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (irdy[k] && !ov[k]) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_valid(input int k);
      bit done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (ov[k]) done = 1'b1;
      end
      if (!done) chk("valid_timeout", 64'd0, 64'd1);
   endtask

   localparam logic [31:0] X1 = 32'h0200_0100;
   localparam logic [63:0] W1 = 64'h0040_FF00_0080_0100;

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; w_bus[k] = '0; x_bus[k] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_in_ready_%0d", k),  64'(irdy[k]),  64'd1);
         chk($sformatf("rst_out_valid_%0d", k), 64'(ov[k]),    64'd0);
         chk($sformatf("rst_busy_%0d", k),      64'(bsy[k]),   64'd0);
         chk($sformatf("rst_y_%0d", k),         64'(y_bus[k]), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // 2x2 linear layer, then busy/in_ready during MAC
      expect_out(0, 32'hFF80_0200, 4);
      send(0, X1, W1);
      @(negedge clk);
      chk("mac_busy", 64'(bsy[0]), 64'd1);
      chk("mac_in_ready", 64'(irdy[0]), 64'd0);
      wait_idle(0);

      // Same stimulus through the ReLU instance
      expect_out(1, 32'h0000_0200, 4);
      send(1, X1, W1);
      wait_idle(1);

      // Positive and negative saturation
      expect_out(0, 32'h7FFF_7FFF, 4);
      send(0, 32'h7F00_7F00, 64'h7F00_7F00_7F00_7F00);
      wait_idle(0);
      expect_out(0, 32'h8000_8000, 4);
      send(0, 32'h7F00_7F00, 64'h8100_8100_8100_8100);
      wait_idle(0);

      // 1x1: truncation toward negative infinity
      expect_out(2, 32'h0000_0000, 1);
      send(2, 32'h0000_0001, 64'h0080);
      wait_idle(2);
      expect_out(2, 32'h0000_FFFF, 1);
      send(2, 32'h0000_FFFF, 64'h0080);
      wait_idle(2);

      // Backpressure with ignored in_valid pulses and changing x_flat
      ordy[0] = 1'b0;
      expect_out(0, 32'hFF80_0200, 4);
      send(0, X1, W1);
      wait_valid(0);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         iv[0]    = n[0];
         x_bus[0] = 32'h1234_5678 + 32'(n);
         @(negedge clk);
         chk("bp_y_stable", 64'(y_bus[0]), 64'hFF80_0200);
         chk("bp_in_ready", 64'(irdy[0]), 64'd0);
         chk("bp_out_valid", 64'(ov[0]), 64'd1);
      end
      @(posedge clk); #1;
      iv[0]   = 1'b0;
      ordy[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_valid", 64'(ov[0]), 64'd0);
      chk("bp_release_ready", 64'(irdy[0]), 64'd1);
      expect_out(0, 32'h7FFF_7FFF, 4);
      send(0, 32'h7F00_7F00, 64'h7F00_7F00_7F00_7F00);
      wait_idle(0);

      // Reset two cycles into MAC, then a clean rerun
      send(0, X1, W1);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 64'(irdy[0]), 64'd1);
      chk("midrst_out_valid", 64'(ov[0]), 64'd0);
      chk("midrst_busy", 64'(bsy[0]), 64'd0);
      chk("midrst_y", 64'(y_bus[0]), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      expect_out(0, 32'hFF80_0200, 4);
      send(0, X1, W1);
      wait_idle(0);

      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("y_queue_empty_%0d", k),   64'(exp_y[k].size()),   64'd0);
         chk($sformatf("lat_queue_empty_%0d", k), 64'(exp_lat[k].size()), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
